// File: rtl/mipi_rx_packet_decoder_if.sv
// Bus between the lane aligner and the CSI-2 packet decoder.
// Carries the aligned HS word stream in, and the forwarded payload plus
// the latched packet descriptors out.
//   data_valid_i    : aligned HS burst word present on data_i
//   data_i          : 4-lane word, lane0 in [7:0], lane3 in [31:24]
//   output_valid_o  : payload word present on data_o
//   data_o          : payload word (zero when output_valid_o is low)
//   packet_type_o   : DI[2:0] of the last accepted long packet
//   packet_length_o : word count of the last accepted long packet
//   packet_error_o  : one-cycle pulse when a payload is cut short
// The slave modport is the decoder's side; the master modport is the source/sink side.
interface mipi_rx_packet_decoder_if;
  logic        data_valid_i;
  logic [31:0] data_i;
  logic        output_valid_o;
  logic [31:0] data_o;
  logic [2:0]  packet_type_o;
  logic [15:0] packet_length_o;
  logic        packet_error_o;

  modport slave (
    input  data_valid_i,
    input  data_i,
    output output_valid_o,
    output data_o,
    output packet_type_o,
    output packet_length_o,
    output packet_error_o
  );

  modport master (
    output data_valid_i,
    output data_i,
    input  output_valid_o,
    input  data_o,
    input  packet_type_o,
    input  packet_length_o,
    input  packet_error_o
  );
endinterface

// File: rtl/mipi_rx_packet_decoder.sv
// CSI-2 long-packet decoder for RAW10/12/14 streams.
// The first word of each HS burst is the packet header. Accepted RAW headers
// latch type and word count, and the payload words that follow are forwarded
// with one cycle of latency. Everything after the payload, and every word of
// a rejected packet, is dropped until the burst ends.
// Ports:
//   clk_i     : byte-domain clock, rising edge
//   reset_n_i : asynchronous reset, active low
//   bus       : slave side of mipi_rx_packet_decoder_if (stream in, payload out)
module mipi_rx_packet_decoder (
  input logic                     clk_i,
  input logic                     reset_n_i,
  mipi_rx_packet_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PAYLOAD  = 2'd1,
    WAIT_END = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] remaining;

  // Header fields. The ECC byte in [31:24] is not checked, and the virtual
  // channel in DI[7:6] does not affect acceptance.
  logic [5:0]  data_type;
  logic [15:0] word_count;
  logic        header_ok;

  always_comb begin
    data_type  = bus.data_i[5:0];
    word_count = {bus.data_i[23:16], bus.data_i[15:8]};
    header_ok  = ((data_type == 6'h2B) || (data_type == 6'h2C) ||
                  (data_type == 6'h2D)) && (word_count != 16'd0);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state               <= IDLE;
      remaining           <= 16'd0;
      bus.output_valid_o  <= 1'b0;
      bus.data_o          <= 32'h0;
      bus.packet_type_o   <= 3'd0;
      bus.packet_length_o <= 16'd0;
      bus.packet_error_o  <= 1'b0;
    end else begin
      // Output strobes default low; data_o stays zero when nothing is forwarded.
      bus.output_valid_o <= 1'b0;
      bus.data_o         <= 32'h0;
      bus.packet_error_o <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.data_valid_i) begin
            if (header_ok) begin
              bus.packet_type_o   <= bus.data_i[2:0];
              bus.packet_length_o <= word_count;
              remaining           <= word_count;
              state               <= PAYLOAD;
            end else begin
              state <= WAIT_END;
            end
          end
        end

        PAYLOAD: begin
          if (bus.data_valid_i) begin
            bus.output_valid_o <= 1'b1;
            bus.data_o         <= bus.data_i;
            // A partial final word still goes out whole; leaving here on
            // remaining <= 4 keeps the counter from ever wrapping.
            if (remaining <= 16'd4) begin
              remaining <= 16'd0;
              state     <= WAIT_END;
            end else begin
              remaining <= remaining - 16'd4;
            end
          end else begin
            // Burst ended before the word count was satisfied.
            bus.packet_error_o <= 1'b1;
            remaining          <= 16'd0;
            state              <= IDLE;
          end
        end

        WAIT_END: begin
          // A new header is only recognised after the burst drops.
          if (!bus.data_valid_i) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_rx_packet_decoder.sv
module tb_mipi_rx_packet_decoder;

  logic clk_i;
  logic reset_n_i;
  int   checks;
  int   errors;

  mipi_rx_packet_decoder_if bus ();

  mipi_rx_packet_decoder dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic [31:0] d,
                         input logic [2:0] typ, input logic [15:0] len, input logic err);
    chk({tag, ".valid"}, {31'd0, bus.output_valid_o}, {31'd0, ov});
    chk({tag, ".data"},  bus.data_o, d);
    chk({tag, ".type"},  {29'd0, bus.packet_type_o}, {29'd0, typ});
    chk({tag, ".len"},   {16'd0, bus.packet_length_o}, {16'd0, len});
    chk({tag, ".err"},   {31'd0, bus.packet_error_o}, {31'd0, err});
  endtask

  // Present one word for one clock; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic v, input logic [31:0] d);
    @(negedge clk_i);
    bus.data_valid_i = v;
    bus.data_i       = d;
    @(posedge clk_i);
    #1;
  endtask

  logic [31:0] p [0:4];

  initial begin
    checks = 0;
    errors = 0;
    p[0] = 32'h11111111; p[1] = 32'h22222222; p[2] = 32'h33333333;
    p[3] = 32'h44444444; p[4] = 32'h55555555;
    bus.data_valid_i = 1'b0;
    bus.data_i       = 32'h0;
    reset_n_i        = 1'b1;
    #1 reset_n_i = 1'b0;
    #2;
    chk_all("reset_async", 1'b0, 32'h0, 3'd0, 16'd0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    chk_all("reset_held", 1'b0, 32'h0, 3'd0, 16'd0, 1'b0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    step(1'b0, 32'h0);
    chk_all("idle", 1'b0, 32'h0, 3'd0, 16'd0, 1'b0);

    // RAW10, WC = 20: five payload words then a footer.
    step(1'b1, 32'hA5_00_14_2B);
    chk_all("raw10_hdr", 1'b0, 32'h0, 3'd3, 16'h0014, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, p[i]);
      chk_all("raw10_pay", 1'b1, p[i], 3'd3, 16'h0014, 1'b0);
    end
    step(1'b1, 32'hDEADBEEF);
    chk_all("raw10_footer", 1'b0, 32'h0, 3'd3, 16'h0014, 1'b0);
    step(1'b0, 32'h0);
    chk_all("raw10_end", 1'b0, 32'h0, 3'd3, 16'h0014, 1'b0);

    // Embedded data DI = 0x12, WC = 8: rejected, descriptors unchanged.
    step(1'b1, 32'h00_00_08_12);
    chk_all("emb_hdr", 1'b0, 32'h0, 3'd3, 16'h0014, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, p[i]);
      chk_all("emb_drop", 1'b0, 32'h0, 3'd3, 16'h0014, 1'b0);
    end
    step(1'b0, 32'h0);

    // RAW12, WC = 10: three words forwarded, the fourth dropped.
    step(1'b1, 32'h00_00_0A_2C);
    chk_all("raw12_hdr", 1'b0, 32'h0, 3'd4, 16'h000A, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, p[i]);
      chk_all("raw12_pay", 1'b1, p[i], 3'd4, 16'h000A, 1'b0);
    end
    step(1'b1, p[3]);
    chk_all("raw12_4th", 1'b0, 32'h0, 3'd4, 16'h000A, 1'b0);
    step(1'b0, 32'h0);

    // RAW14, WC = 16, burst drops after two payload words.
    step(1'b1, 32'h00_00_10_2D);
    chk_all("raw14_hdr", 1'b0, 32'h0, 3'd5, 16'h0010, 1'b0);
    step(1'b1, p[0]);
    chk_all("raw14_pay0", 1'b1, p[0], 3'd5, 16'h0010, 1'b0);
    step(1'b1, p[1]);
    chk_all("raw14_pay1", 1'b1, p[1], 3'd5, 16'h0010, 1'b0);
    step(1'b0, 32'h0);
    chk_all("raw14_abort", 1'b0, 32'h0, 3'd5, 16'h0010, 1'b1);
    step(1'b0, 32'h0);
    chk_all("raw14_pulse_end", 1'b0, 32'h0, 3'd5, 16'h0010, 1'b0);
    // Next burst: RAW10 on VC1, WC = 8.
    step(1'b1, 32'h00_00_08_6B);
    chk_all("after_abort_hdr", 1'b0, 32'h0, 3'd3, 16'h0008, 1'b0);
    step(1'b1, p[2]);
    chk_all("after_abort_pay0", 1'b1, p[2], 3'd3, 16'h0008, 1'b0);
    step(1'b1, p[3]);
    chk_all("after_abort_pay1", 1'b1, p[3], 3'd3, 16'h0008, 1'b0);
    step(1'b1, p[4]);
    chk_all("after_abort_tail", 1'b0, 32'h0, 3'd3, 16'h0008, 1'b0);
    step(1'b0, 32'h0);

    // Short packet followed by a RAW10 header in the same burst.
    step(1'b1, 32'h00_00_00_00);
    chk_all("short_hdr", 1'b0, 32'h0, 3'd3, 16'h0008, 1'b0);
    step(1'b1, 32'h00_00_14_2B);
    chk_all("short_same_burst", 1'b0, 32'h0, 3'd3, 16'h0008, 1'b0);
    step(1'b1, p[0]);
    chk_all("short_drop", 1'b0, 32'h0, 3'd3, 16'h0008, 1'b0);
    step(1'b0, 32'h0);
    step(1'b1, 32'h00_00_0C_2B);
    chk_all("short_new_hdr", 1'b0, 32'h0, 3'd3, 16'h000C, 1'b0);
    step(1'b1, p[0]);
    chk_all("rst_pay0", 1'b1, p[0], 3'd3, 16'h000C, 1'b0);
    step(1'b1, p[1]);
    chk_all("rst_pay1", 1'b1, p[1], 3'd3, 16'h000C, 1'b0);

    // Reset pulsed during payload word 3.
    @(negedge clk_i);
    bus.data_valid_i = 1'b1;
    bus.data_i       = p[2];
    #1 reset_n_i = 1'b0;
    #1;
    chk_all("rst_mid_async", 1'b0, 32'h0, 3'd0, 16'd0, 1'b0);
    @(posedge clk_i);
    #1;
    chk_all("rst_mid_held", 1'b0, 32'h0, 3'd0, 16'd0, 1'b0);
    @(negedge clk_i);
    reset_n_i        = 1'b1;
    bus.data_valid_i = 1'b0;
    // First valid word after release is a header (RAW14, WC = 4).
    step(1'b1, 32'h00_00_04_2D);
    chk_all("post_rst_hdr", 1'b0, 32'h0, 3'd5, 16'h0004, 1'b0);
    step(1'b1, p[3]);
    chk_all("post_rst_pay", 1'b1, p[3], 3'd5, 16'h0004, 1'b0);
    step(1'b1, p[4]);
    chk_all("post_rst_tail", 1'b0, 32'h0, 3'd5, 16'h0004, 1'b0);
    step(1'b0, 32'h0);
    chk_all("post_rst_end", 1'b0, 32'h0, 3'd5, 16'h0004, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
